seg7_mux_driver: RTL and testbench
==================================

# seg7_mux_driver

Parametrised multi-digit seven-segment driver: accepts an unsigned binary value, converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto one shared active-low segment bus with active-low digit enables. It sits between any binary datapath and the board display pins. It replaces per-digit combinational decoders, which need one segment bus per digit.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, 1..8.
- BIN_WIDTH, 14: width of the binary input, 1..27.
- REFRESH_DIV, 50000: clock cycles each digit stays enabled, minimum 2.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bin_in  in  BIN_WIDTH  unsigned value to display.
- load  in  1  sample bin_in; honoured only while busy=0.
- busy  out  1  conversion in progress.
- overflow  out  1  the last accepted value was ≥ 10^NUM_DIGITS.
- seg_n  out  7  segments {g,f,e,d,c,b,a}; 0 = lit.
- an_n  out  NUM_DIGITS  digit enables; 0 = enabled; bit 0 is the least-significant digit.

## Operation
- State machine IDLE → CONV → COMMIT → IDLE.
- IDLE, load=1:
  - capture bin_in into the shift register.
  - clear the BCD scratch register.
  - clear the bit counter.
  - go to CONV.
- CONV: one bit per cycle.
  - add 3 to every scratch nibble ≥ 5.
  - then shift {scratch, shift register} left by 1.
  - after BIN_WIDTH shifts, go to COMMIT.
- COMMIT:
  - copy scratch into the display register in a single cycle. The display never shows a partial result.
  - set overflow = (captured value ≥ 10^NUM_DIGITS).
  - go to IDLE.
- Overflow display: while overflow=1, every digit shows a dash (seg_n = 7'b0111111). The display register still holds the low NUM_DIGITS BCD digits.
- Scan logic:
  - the refresh counter counts 0..REFRESH_DIV-1.
  - at the terminal count it wraps to 0 and the digit index increments.
  - the index wraps from NUM_DIGITS-1 to 0.
  - scanning runs continuously and is independent of the converter state.
- Digit decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - nibbles 10–15 cannot occur; if they do, the digit shows blank (1111111).
- Width rule: scratch register is 4·NUM_DIGITS bits. Bits shifted out of the top are dropped; overflow is computed from the captured binary value, not from the dropped bits.

## Timing
- Reset values:
  - state IDLE, busy=0, overflow=0.
  - display register 0, refresh counter 0, digit index 0.
  - seg_n=7'b1000000, an_n = all ones except bit 0.
- load accepted at edge N:
  - busy=1 from edge N+1.
  - the display register updates at edge N+BIN_WIDTH+1.
  - busy=0 from edge N+BIN_WIDTH+2.
  - total: busy is high for BIN_WIDTH+1 cycles.
- load while busy=1 is ignored, with no queueing. load held high re-triggers on the first IDLE cycle.
- seg_n and an_n are registered.
  - they change one cycle after the digit index changes.
  - exactly one an_n bit is low at all times after reset; this includes across the wrap.
- COMMIT coinciding with a digit advance: the new digit shows the new value. There is no mixed-value frame within one digit slot.
- rst asserted mid-conversion: immediate return to reset values. The previous display contents are discarded.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - any digit above index 0 is blanked (seg_n=7'b1111111, an_n still scans) when it and all more-significant digits are 0.
  - digit 0 is never blanked.
  - overflow dashes override blanking.
- Not defined: all digits always show their value, including leading zeros.

## Test plan
- Reset, then release; NUM_DIGITS=4, REFRESH_DIV=4 → an_n cycles 1110,1101,1011,0111 every 4 cycles; every digit shows 1000000.
- load with bin_in=1234 → busy high for exactly 15 cycles; digits 3..0 then show 1111001, 0100100, 0110000, 0011001.
- load bin_in=10000 (NUM_DIGITS=4) → overflow=1 and all four digits show 0111111; a following load of 9999 → overflow=0 and all digits show 0011000.
- load bin_in=7 with the macro defined → digits 3..1 show 1111111, digit 0 shows 1111000; without the macro, digits 3..1 show 1000000.
- load at edge N, second load with a different value at N+3 → second load ignored; display shows the first value.
- rst pulsed at cycle 5 of a conversion → busy=0 and display 0 on the next sample; a new load then converts correctly.

Source files
------------

// File: rtl/seg7_mux_driver.sv
// ---------------------------------------------------------------------------
// seg7_mux_driver
//
// Multi-digit seven-segment driver. A binary value is converted to packed BCD
// by a sequential shift-add-3 (double-dabble) engine, committed to a display
// register in one cycle, and the digits are time-multiplexed onto one shared
// active-low segment bus with active-low digit enables.
//
// Parameters:
//   NUM_DIGITS   number of multiplexed digits (1..8)
//   BIN_WIDTH    width of the binary input (1..27)
//   REFRESH_DIV  clock cycles each digit stays enabled (>= 2)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   bin_in    in   [BIN_WIDTH]  unsigned value to display
//   load      in   sample bin_in; only honoured while busy=0
//   busy      out  conversion in progress
//   overflow  out  last accepted value was >= 10^NUM_DIGITS
//   seg_n     out  [7] segments {g,f,e,d,c,b,a}, 0 = lit
//   an_n      out  [NUM_DIGITS] digit enables, 0 = enabled, bit 0 = LSD
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, leading zero digits above
//                               digit 0 are blanked (dashes still win).
//
// Converter FSM:
//   state  | meaning
//   IDLE   | waiting for load (accepted only when busy=0)
//   CONV   | one add-3 + shift per cycle, BIN_WIDTH cycles
//   COMMIT | copy scratch to display register, update overflow
// ---------------------------------------------------------------------------
module seg7_mux_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n
);

    localparam int SCR_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int BIT_W = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    function automatic logic [6:0] decode_digit(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [BIN_WIDTH-1:0] shift_reg, shift_nxt;
    logic [SCR_W-1:0]     scratch, scratch_nxt, scratch_adj;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic                 ovf_pend, ovf_pend_nxt;
    logic [SCR_W-1:0]     disp, disp_nxt;
    logic                 ovf_nxt;
    logic                 accept;

    // busy is the registered image of "not IDLE", so it rises one edge
    // after acceptance and falls one edge after the commit.
    assign accept = (state == IDLE) && load && !busy;

    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_reg;
        scratch_nxt  = scratch;
        bit_cnt_nxt  = bit_cnt;
        ovf_pend_nxt = ovf_pend;
        disp_nxt     = disp;
        ovf_nxt      = overflow;
        case (state)
            IDLE: begin
                if (accept) begin
                    shift_nxt    = bin_in;
                    scratch_nxt  = '0;
                    bit_cnt_nxt  = '0;
                    // Overflow comes from the captured value; digits shifted
                    // out of the top of scratch are simply lost.
                    ovf_pend_nxt = (64'(bin_in) >= OVF_LIMIT);
                    state_nxt    = CONV;
                end
            end
            CONV: begin
                {scratch_nxt, shift_nxt} = {scratch_adj, shift_reg} << 1;
                bit_cnt_nxt = bit_cnt + 1'b1;
                if (bit_cnt == BIT_W'(BIN_WIDTH - 1)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                disp_nxt  = scratch;
                ovf_nxt   = ovf_pend;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            ovf_pend  <= 1'b0;
            disp      <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            scratch   <= scratch_nxt;
            bit_cnt   <= bit_cnt_nxt;
            ovf_pend  <= ovf_pend_nxt;
            disp      <= disp_nxt;
            overflow  <= ovf_nxt;
            busy      <= (state != IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Scan: refresh counter and digit index
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] refresh_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic             refresh_tc;
    logic             slot_start;

    assign refresh_tc = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            slot_start  <= 1'b0;
        end else begin
            slot_start <= refresh_tc;
            if (refresh_tc) begin
                refresh_cnt <= '0;
                if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment selection. Segments are latched once per slot, from the
    // value the display register holds after this edge, so a commit on
    // the same edge is shown and a slot never mixes two values.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            cur_nib;
    logic [6:0]            seg_val;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_above;

    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (disp_nxt[4*i +: 4] == 4'd0);
            lz_blank[i] = zero_above;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        cur_nib = disp_nxt[{digit_idx, 2'b00} +: 4];
        if (ovf_nxt) begin
            seg_val = SEG_DASH;
        end else if (lz_blank[digit_idx]) begin
            seg_val = SEG_BLANK;
        end else begin
            seg_val = decode_digit(cur_nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= SEG_ZERO;
            an_n  <= ~NUM_DIGITS'(1);
        end else if (slot_start) begin
            seg_n <= seg_val;
            an_n  <= ~(NUM_DIGITS'(1) << digit_idx);
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_mux_driver
//
// Directed and randomized checks of seg7_mux_driver with a small refresh
// divider. Expected digits come from decimal arithmetic on the loaded value.
// ---------------------------------------------------------------------------
module tb_seg7_mux_driver;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] bin_in;
    logic          load;
    logic          busy;
    logic          overflow;
    logic [6:0]    seg_n;
    logic [ND-1:0] an_n;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seen_seg [ND];

    seg7_mux_driver #(
        .NUM_DIGITS (ND),
        .BIN_WIDTH  (BW),
        .REFRESH_DIV(RD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bin_in  (bin_in),
        .load    (load),
        .busy    (busy),
        .overflow(overflow),
        .seg_n   (seg_n),
        .an_n    (an_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned p10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] digit_pattern(input int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int unsigned v, input int i);
        int unsigned low;
        if (v >= p10(ND)) return 7'b0111111;
        low = v % p10(ND);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (i > 0 && (low / p10(i)) == 0) return 7'b1111111;
`endif
        return digit_pattern((low / p10(i)) % 10);
    endfunction

    task automatic wait_ready();
        for (int n = 0; n < 200 && busy !== 1'b0; n++) @(negedge clk);
        chk("ready_wait", {31'd0, busy}, 32'd0);
    endtask

    // Load at one edge, then measure how many sampled cycles busy stays high.
    task automatic do_load(input int unsigned v, output int busy_len);
        wait_ready();
        bin_in = BW'(v);
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        chk("busy_lag", {31'd0, busy}, 32'd0);
        busy_len = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_len++;
            else if (busy_len > 0) break;
        end
        chk($sformatf("overflow_v%0d", v), {31'd0, overflow},
            (v >= p10(ND)) ? 32'd1 : 32'd0);
    endtask

    task automatic scan_display(input int unsigned v);
        int bad;
        bad = 0;
        repeat (2 * ND * RD) @(negedge clk);
        for (int k = 0; k < ND * RD; k++) begin
            @(negedge clk);
            if ($countones(~an_n) != 1) begin
                bad++;
            end else begin
                for (int i = 0; i < ND; i++) begin
                    if (an_n[i] == 1'b0) seen_seg[i] = seg_n;
                end
            end
        end
        chk("an_onehot", bad, 0);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("digit%0d_v%0d", i, v), {25'd0, seen_seg[i]}, {25'd0, exp_seg(v, i)});
        end
    endtask

    initial begin
        int len;
        int bad;
        int unsigned v;

        rst    = 1'b1;
        load   = 1'b0;
        bin_in = '0;
        for (int i = 0; i < ND; i++) seen_seg[i] = 7'h55;
        repeat (3) @(negedge clk);

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_seg", {25'd0, seg_n}, 32'b1000000);
        chk("rst_an", {28'd0, an_n}, 32'b1110);

        // Each index lasts RD cycles; the registered enables lag it by one.
        rst = 1'b0;
        bad = 0;
        for (int k = 1; k <= 4 * ND * RD; k++) begin
            int d;
            @(negedge clk);
            d = ((k - 1) / RD) % ND;
            if (an_n !== ~(ND'(1) << d)) bad++;
            if (k > RD + 1 && seg_n !== exp_seg(0, d)) bad++;
        end
        chk("an_scan_sequence", bad, 0);

        do_load(1234, len);
        chk("busy_len_1234", len, BW + 1);
        scan_display(1234);

        do_load(10000, len);
        chk("busy_len_10000", len, BW + 1);
        scan_display(10000);

        do_load(9999, len);
        scan_display(9999);

        do_load(7, len);
        scan_display(7);

        do_load(0, len);
        scan_display(0);

        // Second load three edges after the first must be ignored.
        wait_ready();
        bin_in = BW'(1234);
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bin_in = BW'(4321);
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        wait_ready();
        repeat (3) @(negedge clk);
        chk("ignored_load_no_restart", {31'd0, busy}, 32'd0);
        scan_display(1234);

        // Reset in the middle of a conversion.
        wait_ready();
        bin_in = BW'(5678);
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        chk("midrst_seg", {25'd0, seg_n}, 32'b1000000);
        chk("midrst_an", {28'd0, an_n}, 32'b1110);
        @(negedge clk);
        rst = 1'b0;
        scan_display(0);
        do_load(42, len);
        chk("busy_len_42", len, BW + 1);
        scan_display(42);

        for (int r = 0; r < 8; r++) begin
            v = $urandom_range(0, (1 << BW) - 1);
            do_load(v, len);
            chk($sformatf("busy_len_rand%0d", r), len, BW + 1);
            scan_display(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
